// File: rtl/atm_pkg.sv
// Shared types and default widths for the ATM account-database access blocks.
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam int unsigned card_width    = 3;
  localparam int unsigned balance_width = 20;
  localparam int unsigned users_num     = 7;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first eligible terminal at or after rr_ptr, wrapping.
module rr_picker #(
  parameter int unsigned terminals_num = 4,
  parameter int unsigned idx_width     = 2
) (
  input  logic [terminals_num-1:0] eligible,
  input  logic [idx_width-1:0]     rr_ptr,
  output logic [terminals_num-1:0] pick,
  output logic [idx_width-1:0]     index
);

  logic                 found;
  int unsigned          slot;
  logic [idx_width-1:0] slot_idx;

  always_comb begin
    pick     = '0;
    index    = '0;
    found    = 1'b0;
    slot     = 0;
    slot_idx = '0;
    for (int unsigned k = 0; k < terminals_num; k++) begin
      slot     = (32'(rr_ptr) + k) % terminals_num;
      slot_idx = idx_width'(slot);
      if (!found && eligible[slot_idx]) begin
        found          = 1'b1;
        pick[slot_idx] = 1'b1;
        index          = slot_idx;
      end
    end
  end

endmodule

// File: rtl/atm_db_arbiter.sv
// Round-robin arbiter granting ATM terminals exclusive access to the account
// database, with an idle timeout that revokes and masks a stalled terminal.
module atm_db_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned terminals_num  = 4,
  parameter int unsigned card_width     = 3,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [terminals_num-1:0]          req,
  input  logic [terminals_num*card_width-1:0] card_bus,
  input  logic                              db_op_done,
  output logic [terminals_num-1:0]          grant,
  output logic                              grant_valid,
  output logic [card_width-1:0]             db_card_number,
  output logic [terminals_num-1:0]          timeout_err,
  output logic [7:0]                        ops_count
);

  localparam int unsigned idx_width = (terminals_num > 1) ? $clog2(terminals_num) : 1;
  localparam int unsigned tmr_width = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  state_e                   state_q, state_d;
  logic [idx_width-1:0]     rr_ptr_q, rr_ptr_d;
  logic [idx_width-1:0]     gidx_q, gidx_d;
  logic [tmr_width-1:0]     timer_q, timer_d;
  logic [terminals_num-1:0] mask_q, mask_d;
  logic [terminals_num-1:0] grant_d, timeout_err_d;
  logic                     grant_valid_d;
  logic [card_width-1:0]    card_d;
  logic [7:0]               ops_d;

  logic [terminals_num-1:0] eligible, pick;
  logic [idx_width-1:0]     pick_idx;
  logic [card_width-1:0]    cards [terminals_num];

  for (genvar g = 0; g < terminals_num; g++) begin : g_cards
    assign cards[g] = card_bus[g*card_width +: card_width];
  end

  assign eligible = req & ~mask_q;

  rr_picker #(
    .terminals_num(terminals_num),
    .idx_width    (idx_width)
  ) u_picker (
    .eligible(eligible),
    .rr_ptr  (rr_ptr_q),
    .pick    (pick),
    .index   (pick_idx)
  );

  // Next-state and registered-output logic; release beats op_done beats timeout.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gidx_d        = gidx_q;
    timer_d       = timer_q;
    mask_d        = mask_q & req;
    grant_d       = grant;
    grant_valid_d = grant_valid;
    card_d        = db_card_number;
    timeout_err_d = '0;
    ops_d         = ops_count;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d       = GRANT;
          grant_d       = pick;
          grant_valid_d = 1'b1;
          card_d        = cards[pick_idx];
          gidx_d        = pick_idx;
          rr_ptr_d      = (pick_idx == idx_width'(terminals_num - 1)) ? '0 : pick_idx + 1'b1;
          timer_d       = '0;
        end
      end
      GRANT: begin
        if (db_op_done && ops_count != 8'hFF) ops_d = ops_count + 8'd1;
        if (!req[gidx_q]) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timer_d       = '0;
        end else if (db_op_done) begin
          timer_d = '0;
        end else if (timer_q == tmr_width'(timeout_cycles - 1)) begin
          state_d       = HOLDOFF;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timeout_err_d = grant;
          mask_d        = (mask_q & req) | grant;
          timer_d       = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      gidx_q         <= '0;
      timer_q        <= '0;
      mask_q         <= '0;
      grant          <= '0;
      grant_valid    <= 1'b0;
      db_card_number <= '0;
      timeout_err    <= '0;
      ops_count      <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      gidx_q         <= gidx_d;
      timer_q        <= timer_d;
      mask_q         <= mask_d;
      grant          <= grant_d;
      grant_valid    <= grant_valid_d;
      db_card_number <= card_d;
      timeout_err    <= timeout_err_d;
      ops_count      <= ops_d;
    end
  end

endmodule

// File: tb/tb_atm_db_arbiter.sv
// Self-checking bench for atm_db_arbiter: directed vector table, corner-case
// sequences and a randomized run against a session-level reference model.
module tb_atm_db_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned T  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] card_bus;
  logic            db_op_done;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [CW-1:0]   db_card_number;
  logic [N-1:0]    timeout_err;
  logic [7:0]      ops_count;

  always #5 clk = ~clk;

  atm_db_arbiter #(
    .terminals_num (N),
    .card_width    (CW),
    .timeout_cycles(T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .card_bus      (card_bus),
    .db_op_done    (db_op_done),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .db_card_number(db_card_number),
    .timeout_err   (timeout_err),
    .ops_count     (ops_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the database, how long they have been idle,
  // who is locked out after a timeout, and where the next search starts.
  int owner;
  bit cooling;
  int idle_cycles;
  int next_start;
  int ops;
  bit locked[N];
  int latched_card;
  int err_term;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; cooling = 0; idle_cycles = 0; next_start = 0;
    ops = 0; latched_card = 0; err_term = -1;
    for (int i = 0; i < N; i++) locked[i] = 0;
  endtask

  function automatic int card_of(input int i);
    logic [N*CW-1:0] tmp;
    tmp = card_bus >> (i * CW);
    return int'(tmp[CW-1:0]);
  endfunction

  task automatic model_clock();
    bit nlock[N];
    bit found;
    err_term = -1;
    for (int i = 0; i < N; i++) nlock[i] = locked[i] && req[i];
    if (owner >= 0) begin
      if (db_op_done && ops < 255) ops++;
      if (!req[owner]) owner = -1;
      else if (db_op_done) idle_cycles = 0;
      else if (idle_cycles == T - 1) begin
        err_term = owner; nlock[owner] = 1; owner = -1; cooling = 1;
      end else idle_cycles++;
    end else if (cooling) begin
      cooling = 0;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (next_start + k) % N;
        if (!found && req[i] && !locked[i]) begin
          found = 1; owner = i; latched_card = card_of(i);
          next_start = (i + 1) % N; idle_cycles = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) locked[i] = nlock[i];
  endtask

  task automatic compare_model();
    check("grant", int'(grant), owner >= 0 ? (1 << owner) : 0);
    check("grant_valid", int'(grant_valid), owner >= 0 ? 1 : 0);
    check("card", int'(db_card_number), latched_card);
    check("timeout_err", int'(timeout_err), err_term >= 0 ? (1 << err_term) : 0);
    check("ops_count", int'(ops_count), ops);
    check("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; db_op_done = 1'b0;
    model_reset();
    @(negedge clk);
    compare_model();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] exp_grant;
    int           exp_ops;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Round-robin with 3-cycle sessions and a forced release gap.
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0001, 1};
    tbl[3]  = '{4'b1110, 1'b1, 4'b0000, 2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 2};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 3};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0010, 3};
    tbl[7]  = '{4'b1101, 1'b0, 4'b0000, 3};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0100, 3};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0100, 3};
    tbl[10] = '{4'b1111, 1'b0, 4'b0100, 3};
    tbl[11] = '{4'b1011, 1'b0, 4'b0000, 3};
    tbl[12] = '{4'b1111, 1'b0, 4'b1000, 3};
    tbl[13] = '{4'b1111, 1'b0, 4'b1000, 3};
    tbl[14] = '{4'b1111, 1'b0, 4'b1000, 3};
    tbl[15] = '{4'b0111, 1'b0, 4'b0000, 3};
    tbl[16] = '{4'b1111, 1'b0, 4'b0001, 3};

    rst = 1'b0; req = '0; db_op_done = 1'b0; card_bus = 12'o7531;
    model_reset();
    #2;
    check("reset_grant", int'(grant), 0);
    check("reset_ops", int'(ops_count), 0);

    do_reset();
    for (int v = 0; v < 17; v++) begin
      req = tbl[v].req; db_op_done = tbl[v].done;
      step();
      check($sformatf("tbl%0d_grant", v), int'(grant), int'(tbl[v].exp_grant));
      check($sformatf("tbl%0d_ops", v), int'(ops_count), tbl[v].exp_ops);
    end

    // Card number is latched at grant and ignores later bus changes.
    do_reset();
    card_bus = '0; card_bus[2*CW +: CW] = 3'd5; req = 4'b0100;
    step();
    check("latch_grant", int'(grant), 4);
    check("latch_card", int'(db_card_number), 5);
    card_bus[2*CW +: CW] = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("latch_hold", int'(db_card_number), 5);
    end
    req = '0;
    step();
    check("latch_release", int'(grant), 0);

    // Idle timeout revokes, pulses error once and locks out until req drops.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < T; i++) step();
    check("to_held", int'(grant), 2);
    step();
    check("to_err", int'(timeout_err), 2);
    check("to_drop", int'(grant), 0);
    step();
    check("to_err_pulse", int'(timeout_err), 0);
    step();
    check("to_locked", int'(grant), 0);
    req = '0;
    step();
    req = 4'b0010;
    step();
    check("to_regrant", int'(grant), 2);

    // op_done on the timeout cycle keeps the grant.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < T; i++) step();
    db_op_done = 1'b1;
    step();
    db_op_done = 1'b0;
    check("race_err", int'(timeout_err), 0);
    check("race_grant", int'(grant), 2);
    check("race_ops", int'(ops_count), 1);

    // Operation counter saturates.
    do_reset();
    req = 4'b0001;
    step();
    db_op_done = 1'b1;
    for (int i = 0; i < 300; i++) step();
    db_op_done = 1'b0;
    check("sat_ops", int'(ops_count), 255);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0100; db_op_done = 1'b1;
    step(); step();
    db_op_done = 1'b0;
    check("mid_pre_grant", int'(grant), 4);
    #2;
    rst = 1'b0;
    #1;
    check("mid_grant", int'(grant), 0);
    check("mid_valid", int'(grant_valid), 0);
    check("mid_card", int'(db_card_number), 0);
    check("mid_err", int'(timeout_err), 0);
    check("mid_ops", int'(ops_count), 0);
    model_reset();
    req = 4'b0110;
    @(negedge clk);
    rst = 1'b1;
    step();
    check("mid_restart", int'(grant), 2);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int done_div;
      done_div = ((c / 500) % 2 == 0) ? 3 : 40;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7, 0) == 0) req[i] = ~req[i];
      db_op_done = ($urandom_range(done_div - 1, 0) == 0);
      card_bus = N*CW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_db_arbiter.md
ATM_DB_ARBITER -- requirements
Module: atm_db_arbiter

Interface
REQ-001 The module SHALL have parameter terminals_num, default 4, meaning number of ATM terminals sharing the account database.
REQ-002 The module SHALL have parameter card_width, default 3, meaning card number width.
REQ-003 The module SHALL have parameter timeout_cycles, default 16, meaning maximum idle cycles a grant is held without db_op_done.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port req, input, terminals_num bits: per-terminal database access request, level-held for the whole session.
REQ-007 The module SHALL have port card_bus, input, terminals_num*card_width bits: card number of terminal i in slice [i*card_width +: card_width].
REQ-008 The module SHALL have port db_op_done, input, 1 bit: one-cycle pulse from the database datapath when an operation completes.
REQ-009 The module SHALL have port grant, output, terminals_num bits: one-hot, registered grant.
REQ-010 The module SHALL have port grant_valid, output, 1 bit: OR of grant.
REQ-011 The module SHALL have port db_card_number, output, card_width bits: card number of the granted terminal, latched at grant.
REQ-012 The module SHALL have port timeout_err, output, terminals_num bits: one-cycle pulse on the terminal whose grant was revoked.
REQ-013 The module SHALL have port ops_count, output, 8 bits: saturating count of completed operations.

Function
REQ-014 The FSM SHALL have three states, IDLE, GRANT and HOLDOFF, all registered.
REQ-015 In IDLE with at least one eligible req bit, the FSM SHALL select the first eligible terminal at or after rr_ptr (wrapping modulo terminals_num), assert its grant bit on the next edge, and enter GRANT.
REQ-016 A terminal SHALL be eligible when its req bit is high and its mask bit is clear.
REQ-017 At each grant, db_card_number SHALL latch that terminal's card_bus slice and hold it, unaffected by later card_bus changes, for the whole GRANT state.
REQ-018 At each grant, rr_ptr SHALL load (granted index + 1) mod terminals_num.
REQ-019 In GRANT, when req of the granted terminal is low, grant SHALL drop on the next edge and the FSM SHALL return to IDLE; re-arbitration then occurs from IDLE, so there is a minimum 1-cycle gap between grants.
REQ-020 In GRANT, the idle timer SHALL increment each cycle and reset to 0 on db_op_done.
REQ-021 When the idle timer reaches timeout_cycles-1 without db_op_done or release, the block SHALL drop grant, pulse timeout_err of the granted terminal for one cycle, set that terminal's mask bit, and enter HOLDOFF.
REQ-022 HOLDOFF SHALL last exactly one cycle, then go to IDLE.
REQ-023 A mask bit SHALL clear on the first cycle the terminal's req is low.
REQ-024 If db_op_done and timeout coincide, db_op_done SHALL win: no timeout, and the timer clears.
REQ-025 If release and db_op_done coincide, the operation SHALL be counted and the release SHALL take effect.
REQ-026 ops_count SHALL increment on db_op_done only in GRANT and SHALL saturate at 255.
REQ-027 db_op_done SHALL be ignored in IDLE and HOLDOFF.
REQ-028 grant SHALL never have more than one bit set.
REQ-029 No terminal with continuous req SHALL wait more than terminals_num-1 grants (round-robin fairness).

Reset
REQ-030 On rst low, the block SHALL asynchronously enter IDLE with grant=0, grant_valid=0, db_card_number=0, timeout_err=0, ops_count=0, rr_ptr=0, timer=0 and mask=0.
REQ-031 Reset asserted mid-GRANT SHALL drop grant immediately, without a timeout_err pulse.
REQ-032 After rst releases, arbitration SHALL restart from terminal 0.

Structure
REQ-033 A shared package atm_pkg SHALL hold the FSM state enum (IDLE/GRANT/HOLDOFF) and the default widths card_width=3, balance_width=20 and users_num=7.
REQ-034 The round-robin pick SHALL be a sub-module rr_picker: combinational, with inputs eligible vector and rr_ptr and outputs one-hot pick and index.

Verification
REQ-035 Bench scenario, round-robin: req=4'b1111 held, each grantee releases after 3 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with a 1-cycle gap between grants.
REQ-036 Bench scenario, card latch: req[2]=1 with card slice 3'd5, then slice changes to 3'd1 during the grant -> db_card_number stays 5 until release.
REQ-037 Bench scenario, timeout: req[1] held with no db_op_done for 16 cycles -> timeout_err=4'b0010 for one cycle, grant=0; terminal 1 is not regranted until req[1] has gone low for one cycle.
REQ-038 Bench scenario, op_done beats timeout: db_op_done on the timeout cycle -> no timeout_err, grant held, ops_count+1.
REQ-039 Bench scenario, saturation: 300 db_op_done pulses within grants -> ops_count=255.
REQ-040 Bench scenario, mid-grant reset: rst low while grant=4'b0100 -> all outputs 0 asynchronously; after release with req=4'b0110, first grant=4'b0010.
